debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel debouncer for the board push-buttons and switches feeding the rv32i_mono MMIO/GPIO peripheral. Each channel synchronises its raw asynchronous pin, filters bounce with its own stability counter, and produces a clean pressed-level plus single-cycle press and release strobes. An optional long-press detector also produces a one-shot long-press strobe. The block replaces per-button debouncer instances with one bank that software polls or latches through the GPIO register file.

## Interface
- `N_CH`, default 4: number of independent channels.
- `DEBOUNCE_TIME`, default 500000: consecutive stable cycles required before a level change is accepted; must be ≥ 1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel; must be ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means a raw pin at 0 is "pressed"; 0 means a raw pin at 1 is "pressed".
- `LONG_PRESS_TIME`, default 50000000: cycles of accepted press before `btn_long` fires; used only with the macro.
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in `N_CH`: raw asynchronous button pins.
- `btn_level` out `N_CH`: debounced state, 1 = pressed, independent of polarity.
- `btn_press` out `N_CH`: one-cycle strobe on an accepted press.
- `btn_release` out `N_CH`: one-cycle strobe on an accepted release.
- `btn_long` out `N_CH`: one-cycle long-press strobe; tied to 0 when the feature is compiled out.

## Operation
- Per channel, there is a `SYNC_STAGES` flop chain. Its reset value is the unpressed raw level: 1 if `ACTIVE_LOW`, otherwise 0.
- Normalised sample: `p = ACTIVE_LOW ? ~sync_out : sync_out`.
- Stability counter, width `$clog2(DEBOUNCE_TIME+1)`, behaves as follows:
  - `p == btn_level`: counter is cleared to 0.
  - `p != btn_level` and counter `< DEBOUNCE_TIME-1`: counter increments.
  - `p != btn_level` and counter `== DEBOUNCE_TIME-1`: `btn_level <= p`, counter clears, and `btn_press` (if `p` = 1) or `btn_release` (if `p` = 0) is asserted for that one cycle.
- Any return of `p` to `btn_level` before the threshold discards the attempt. A bounce therefore restarts the count, and a glitch shorter than `DEBOUNCE_TIME` cycles has no effect.
- Channels are fully independent. Simultaneous events on several channels produce strobes in the same cycle.
- `btn_press` and `btn_release` are never high together on one channel. Each is high for at most one cycle per accepted transition.
- Long-press counter: it counts while `btn_level` = 1 and saturates after firing. `btn_long` pulses once when the count reaches `LONG_PRESS_TIME-1`, at most once per press. The counter clears when `btn_level` = 0.

## Timing
- Reset (synchronous, takes effect at the next clock edge with `rst` = 1):
  - All outputs go to 0.
  - All counters go to 0.
  - Synchronisers go to the unpressed level.
  - Any in-progress debounce is discarded.
- A button held through reset release is treated as a new press after the full latency.
- Latency: let edge 0 be the first clock edge that samples a new raw value held stable. `btn_level` and its strobe update at edge `SYNC_STAGES + DEBOUNCE_TIME - 1`.
- `btn_long` asserts `LONG_PRESS_TIME` edges after the edge at which `btn_level` rose.
- Outputs are all registered. There is no combinational path from `btn_in` to any output.

## Configuration
- `DEBOUNCE_LONGPRESS_EN` defined: the long-press counters and `btn_long` logic are compiled in.
- `DEBOUNCE_LONGPRESS_EN` undefined: no long-press counters are built, `btn_long` is constant 0, and `LONG_PRESS_TIME` is ignored. The port list is identical either way.

## Structure
- Package `debounce_pkg` contains:
  - the function `ms_to_cycles(clk_hz, ms)` for deriving `DEBOUNCE_TIME` and `LONG_PRESS_TIME`;
  - the default constant `DEBOUNCE_CLK_HZ = 50_000_000`.
- Sub-module `debounce_channel` holds one channel: synchroniser, stability counter, level/strobe registers, and the optional long-press counter. `debounce_bank` instantiates it `N_CH` times in a generate loop.

## Test plan
Bench parameters: `N_CH`=4, `DEBOUNCE_TIME`=100, `SYNC_STAGES`=2, `LONG_PRESS_TIME`=1000, `ACTIVE_LOW`=1, 50 MHz clock.
- Clean press: `btn_in[0]` is driven 1→0 and held 300 cycles. `btn_level[0]` rises at edge 101 after first sample, `btn_press[0]` is high exactly one cycle, and channels 1–3 stay 0.
- Bounce: `btn_in[0]` toggles low 2, high 1, low 2, high 1 cycles, then stays low. There is exactly one `btn_press[0]`, 101 edges after the final transition. A mirrored release bounce gives exactly one `btn_release[0]`.
- Glitch threshold (sync-domain length): a low pulse of 99 cycles gives no level change and no strobes. A low pulse of 100 cycles gives `btn_level[0]`=1 and one `btn_press[0]`.
- Simultaneous: `btn_in[1]` and `btn_in[3]` are pressed on the same edge, and both press strobes fire in the same cycle. Releasing ch1 while ch3 is held gives only `btn_release[1]`, and `btn_level[3]` stays 1.
- Long press (macro on):
  - Hold ch2 for 1200 accepted cycles: one `btn_long[2]` pulse, 1000 edges after `btn_level[2]` rose.
  - Release at 900 cycles: no pulse.
  - Macro off: `btn_long` stays 0 throughout.
- Reset mid-operation: assert `rst` 50 cycles into a ch0 debounce count. All outputs are 0 the next cycle. With the button still held after `rst` falls, `btn_press[0]` fires after the full 101-edge latency, not the remaining 50.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: clock default, ms->cycle helper,
// and the per-channel event encoding used between comb and registered logic.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_RELEASE = 2'd2
    } event_e;

    function automatic int unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned ms);
        longint unsigned cycles;
        cycles = (clk_hz * ms) / 64'd1000;
        return 32'(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, level/strobe registers
// and, with DEBOUNCE_LONGPRESS_EN defined, a saturating long-press detector.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_TIME   = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_PRESS_TIME = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int              CW       = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_TIME - 1);
    localparam logic            IDLE_LVL = (ACTIVE_LOW != 0);

    if (DEBOUNCE_TIME < 1 || SYNC_STAGES < 2 || LONG_PRESS_TIME < 1) begin : g_bad_param
        $error("debounce_channel: DEBOUNCE_TIME>=1, SYNC_STAGES>=2, LONG_PRESS_TIME>=1 required");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, release_q;
    logic                   sample;
    event_e                 ev_d;

    assign sample = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    // A disagreement must persist DEBOUNCE_TIME consecutive cycles; any agreement restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        ev_d    = EV_NONE;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
                ev_d    = sample ? EV_PRESS : EV_RELEASE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {SYNC_STAGES{IDLE_LVL}};
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= (ev_d == EV_PRESS);
            release_q <= (ev_d == EV_RELEASE);
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int            LW        = $clog2(LONG_PRESS_TIME + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_TIME - 1);

    logic [LW-1:0] long_cnt_q;
    logic          long_q;

    // Counter parks one past the firing value so the strobe happens once per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!level_q) begin
                long_cnt_q <= '0;
            end else if (long_cnt_q < LONG_LAST) begin
                long_cnt_q <= long_cnt_q + 1'b1;
            end else if (long_cnt_q == LONG_LAST) begin
                long_q     <= 1'b1;
                long_cnt_q <= long_cnt_q + 1'b1;
            end
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels for the GPIO buttons/switches.
// Define DEBOUNCE_LONGPRESS_EN to build the long-press detectors.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_TIME   = int'(ms_to_cycles(DEBOUNCE_CLK_HZ, 10)),
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_PRESS_TIME = int'(ms_to_cycles(DEBOUNCE_CLK_HZ, 1000))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_TIME   (DEBOUNCE_TIME),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .LONG_PRESS_TIME (LONG_PRESS_TIME)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_i     (btn_in[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .long_o    (btn_long[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed testbench for debounce_bank (4 channels, DEBOUNCE_TIME=100, active-low pins).
// Long-press expectations follow DEBOUNCE_LONGPRESS_EN.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = 4'hF;
    logic [3:0] btn_level, btn_press, btn_release, btn_long;

    int compared = 0;
    int mismatched = 0;

    int edgeNo;
    int pressCnt[4], releaseCnt[4], longCnt[4], levelHigh[4];
    int firstPress[4], firstRelease[4], firstLong[4];
    int bothHigh = 0;

    debounce_bank #(
        .N_CH            (4),
        .DEBOUNCE_TIME   (100),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW      (1),
        .LONG_PRESS_TIME (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #10 clk = ~clk;

    // Edge numbering restarts here: the next posedge after this call is edge 0.
    task automatic clearStats();
        edgeNo = 0;
        for (int c = 0; c < 4; c++) begin
            pressCnt[c] = 0; releaseCnt[c] = 0; longCnt[c] = 0; levelHigh[c] = 0;
            firstPress[c] = -1; firstRelease[c] = -1; firstLong[c] = -1;
        end
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (btn_press[c] === 1'b1) begin
                    pressCnt[c]++;
                    if (firstPress[c] < 0) firstPress[c] = edgeNo;
                end
                if (btn_release[c] === 1'b1) begin
                    releaseCnt[c]++;
                    if (firstRelease[c] < 0) firstRelease[c] = edgeNo;
                end
                if (btn_long[c] === 1'b1) begin
                    longCnt[c]++;
                    if (firstLong[c] < 0) firstLong[c] = edgeNo;
                end
                if (btn_level[c] === 1'b1) levelHigh[c]++;
                if (btn_press[c] === 1'b1 && btn_release[c] === 1'b1) bothHigh++;
            end
            edgeNo++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 4'hF;
        observe(3);
        compared++;
        if ({btn_level, btn_press, btn_release, btn_long} !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected 0000", {btn_level, btn_press, btn_release, btn_long});
        end
        rst = 1'b0;
        clearStats();
        observe(20);
        compared++;
        if (levelHigh[0] + levelHigh[1] + levelHigh[2] + levelHigh[3] + pressCnt[0] + pressCnt[1] + pressCnt[2] + pressCnt[3] !== 0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: got activity, expected none");
        end
    endtask

    task automatic test_clean_press();
        clearStats();
        btn_in[0] = 1'b0;
        observe(300);
        compared++;
        if (firstPress[0] !== 101) begin
            mismatched++;
            $display("[TB] FAIL clean_press_edge: got %0d expected 101", firstPress[0]);
        end
        compared++;
        if (pressCnt[0] !== 1) begin
            mismatched++;
            $display("[TB] FAIL clean_press_count: got %0d expected 1", pressCnt[0]);
        end
        compared++;
        if (levelHigh[0] !== 199) begin
            mismatched++;
            $display("[TB] FAIL clean_level_cycles: got %0d expected 199", levelHigh[0]);
        end
        compared++;
        if (pressCnt[1] + pressCnt[2] + pressCnt[3] + levelHigh[1] + levelHigh[2] + levelHigh[3] !== 0) begin
            mismatched++;
            $display("[TB] FAIL clean_other_ch: got activity on ch1-3, expected none");
        end
        clearStats();
        btn_in[0] = 1'b1;
        observe(300);
        compared++;
        if (firstRelease[0] !== 101 || releaseCnt[0] !== 1) begin
            mismatched++;
            $display("[TB] FAIL clean_release: got edge %0d count %0d expected edge 101 count 1", firstRelease[0], releaseCnt[0]);
        end
        compared++;
        if (levelHigh[0] !== 101 || pressCnt[0] !== 0) begin
            mismatched++;
            $display("[TB] FAIL clean_release_level: got level %0d press %0d expected 101 and 0", levelHigh[0], pressCnt[0]);
        end
    endtask

    task automatic test_bounce();
        clearStats();
        for (int t = 0; t < 400; t++) begin
            btn_in[0] = (t == 2 || t == 5) ? 1'b1 : 1'b0;
            observe(1);
        end
        compared++;
        if (pressCnt[0] !== 1 || firstPress[0] !== 107) begin
            mismatched++;
            $display("[TB] FAIL bounce_press: got count %0d edge %0d expected 1 at 107", pressCnt[0], firstPress[0]);
        end
        clearStats();
        for (int t = 0; t < 400; t++) begin
            btn_in[0] = (t == 2 || t == 5) ? 1'b0 : 1'b1;
            observe(1);
        end
        compared++;
        if (releaseCnt[0] !== 1 || firstRelease[0] !== 107 || pressCnt[0] !== 0) begin
            mismatched++;
            $display("[TB] FAIL bounce_release: got count %0d edge %0d press %0d expected 1 at 107, 0 press",
                     releaseCnt[0], firstRelease[0], pressCnt[0]);
        end
    endtask

    task automatic test_glitch();
        clearStats();
        btn_in[0] = 1'b0;
        observe(99);
        btn_in[0] = 1'b1;
        observe(300);
        compared++;
        if (pressCnt[0] + releaseCnt[0] + levelHigh[0] !== 0) begin
            mismatched++;
            $display("[TB] FAIL glitch_99: got press %0d release %0d level %0d expected all 0",
                     pressCnt[0], releaseCnt[0], levelHigh[0]);
        end
        clearStats();
        btn_in[0] = 1'b0;
        observe(100);
        btn_in[0] = 1'b1;
        observe(300);
        compared++;
        if (pressCnt[0] !== 1 || firstPress[0] !== 101) begin
            mismatched++;
            $display("[TB] FAIL glitch_100_press: got count %0d edge %0d expected 1 at 101", pressCnt[0], firstPress[0]);
        end
        compared++;
        if (levelHigh[0] !== 100 || releaseCnt[0] !== 1 || firstRelease[0] !== 201) begin
            mismatched++;
            $display("[TB] FAIL glitch_100_level: got level %0d release %0d at %0d expected 100, 1 at 201",
                     levelHigh[0], releaseCnt[0], firstRelease[0]);
        end
    endtask

    task automatic test_simultaneous();
        clearStats();
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b0;
        observe(300);
        compared++;
        if (firstPress[1] !== 101 || firstPress[3] !== 101) begin
            mismatched++;
            $display("[TB] FAIL simul_press_edge: got ch1 %0d ch3 %0d expected 101 both", firstPress[1], firstPress[3]);
        end
        compared++;
        if (pressCnt[1] !== 1 || pressCnt[3] !== 1 || pressCnt[0] + pressCnt[2] !== 0) begin
            mismatched++;
            $display("[TB] FAIL simul_press_count: got %0d %0d %0d %0d expected 0 1 0 1",
                     pressCnt[0], pressCnt[1], pressCnt[2], pressCnt[3]);
        end
        clearStats();
        btn_in[1] = 1'b1;
        observe(300);
        compared++;
        if (releaseCnt[1] !== 1 || releaseCnt[3] !== 0) begin
            mismatched++;
            $display("[TB] FAIL simul_release: got ch1 %0d ch3 %0d expected 1 and 0", releaseCnt[1], releaseCnt[3]);
        end
        compared++;
        if (levelHigh[3] !== 300) begin
            mismatched++;
            $display("[TB] FAIL simul_ch3_held: got %0d expected 300", levelHigh[3]);
        end
        clearStats();
        btn_in[3] = 1'b1;
        observe(300);
        compared++;
        if (releaseCnt[3] !== 1 || firstRelease[3] !== 101) begin
            mismatched++;
            $display("[TB] FAIL simul_ch3_release: got count %0d edge %0d expected 1 at 101", releaseCnt[3], firstRelease[3]);
        end
    endtask

    task automatic test_long_press();
        int expLongCnt;
        int expLongEdge;
`ifdef DEBOUNCE_LONGPRESS_EN
        expLongCnt  = 1;
        expLongEdge = 1101;
`else
        expLongCnt  = 0;
        expLongEdge = -1;
`endif
        clearStats();
        btn_in[2] = 1'b0;
        observe(1400);
        compared++;
        if (firstPress[2] !== 101) begin
            mismatched++;
            $display("[TB] FAIL long_press_edge: got %0d expected 101", firstPress[2]);
        end
        compared++;
        if (longCnt[2] !== expLongCnt || firstLong[2] !== expLongEdge) begin
            mismatched++;
            $display("[TB] FAIL long_pulse: got count %0d edge %0d expected %0d at %0d",
                     longCnt[2], firstLong[2], expLongCnt, expLongEdge);
        end
        compared++;
        if (longCnt[0] + longCnt[1] + longCnt[3] !== 0) begin
            mismatched++;
            $display("[TB] FAIL long_other_ch: got %0d expected 0", longCnt[0] + longCnt[1] + longCnt[3]);
        end
        btn_in[2] = 1'b1;
        observe(300);
        clearStats();
        btn_in[2] = 1'b0;
        observe(900);
        btn_in[2] = 1'b1;
        observe(600);
        compared++;
        if (longCnt[2] !== 0 || levelHigh[2] !== 900) begin
            mismatched++;
            $display("[TB] FAIL long_short_hold: got long %0d level %0d expected 0 and 900", longCnt[2], levelHigh[2]);
        end
    endtask

    task automatic test_reset_mid();
        clearStats();
        btn_in[3] = 1'b0;
        observe(200);
        clearStats();
        btn_in[0] = 1'b0;
        observe(50);
        rst = 1'b1;
        observe(1);
        compared++;
        if ({btn_level, btn_press, btn_release, btn_long} !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_outputs: got %h expected 0000", {btn_level, btn_press, btn_release, btn_long});
        end
        rst = 1'b0;
        clearStats();
        observe(300);
        compared++;
        if (firstPress[0] !== 101 || pressCnt[0] !== 1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_ch0: got edge %0d count %0d expected 101 and 1", firstPress[0], pressCnt[0]);
        end
        compared++;
        if (firstPress[3] !== 101) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_ch3: got %0d expected 101", firstPress[3]);
        end
        btn_in = 4'hF;
        observe(300);
    endtask

    initial begin
        clearStats();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_long_press();
        test_reset_mid();
        compared++;
        if (bothHigh !== 0) begin
            mismatched++;
            $display("[TB] FAIL press_release_overlap: got %0d expected 0", bothHigh);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
